// File: rtl/render_fetch_pkg.sv
// Shared render-path parameters and the cell-state RAM word layout.
// Field offsets into a RAM word come only from cell_word_t.
package render_fetch_pkg;

    localparam int CELL_SHIFT  = 3;
    localparam int GRID_W      = 80;
    localparam int GRID_H      = 60;
    localparam int ADDR_W      = 13;
    localparam int SIGNAL_bits = 9;
    localparam int COORD_W     = 10;

    typedef struct packed {
        logic                   ant;
        logic                   sugar;
        logic                   nest;
        logic [SIGNAL_bits-1:0] signal;
    } cell_word_t;

endpackage

// File: rtl/render_fetch_pixel_to_cell.sv
// Combinational pixel coordinate to grid cell mapping.
// Shared by the render fetch path and the mouse-pick logic.
module pixel_to_cell #(
    parameter int CELL_SHIFT = render_fetch_pkg::CELL_SHIFT,
    parameter int GRID_W     = render_fetch_pkg::GRID_W,
    parameter int GRID_H     = render_fetch_pkg::GRID_H,
    parameter int ADDR_W     = render_fetch_pkg::ADDR_W,
    parameter int COORD_W    = render_fetch_pkg::COORD_W
) (
    input  logic [COORD_W-1:0]            x,
    input  logic [COORD_W-1:0]            y,
    input  logic                          valid,
    output logic [COORD_W-CELL_SHIFT-1:0] col,
    output logic [COORD_W-CELL_SHIFT-1:0] row,
    output logic                          in_grid,
    output logic                          interior,
    output logic [ADDR_W-1:0]             addr
);

    localparam logic [CELL_SHIFT-1:0] SUB_MAX = '1;

    logic [CELL_SHIFT-1:0] sub_x;
    logic [CELL_SHIFT-1:0] sub_y;

    assign col   = x[COORD_W-1:CELL_SHIFT];
    assign row   = y[COORD_W-1:CELL_SHIFT];
    assign sub_x = x[CELL_SHIFT-1:0];
    assign sub_y = y[CELL_SHIFT-1:0];

    assign in_grid = valid
                  && (32'(col) < GRID_W)
                  && (32'(row) < GRID_H);

    // interior excludes the one-pixel ring on every cell edge
    assign interior = (sub_x != '0) && (sub_x != SUB_MAX)
                   && (sub_y != '0) && (sub_y != SUB_MAX);

    assign addr = ADDR_W'(row) * ADDR_W'(GRID_W) + ADDR_W'(col);

endmodule

// File: rtl/render_fetch.sv
// Per-pixel cell-state fetch feeding the colour mapper.
// Three-edge pipeline: address/sideband, RAM read, output registers.
module render_fetch #(
    parameter int CELL_SHIFT  = render_fetch_pkg::CELL_SHIFT,
    parameter int GRID_W      = render_fetch_pkg::GRID_W,
    parameter int GRID_H      = render_fetch_pkg::GRID_H,
    parameter int ADDR_W      = render_fetch_pkg::ADDR_W,
    parameter int SIGNAL_BITS = render_fetch_pkg::SIGNAL_bits
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   pix_valid,
    input  logic [ADDR_W-1:0]      view_loc,
    input  logic [ADDR_W-1:0]      write_loc,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [SIGNAL_BITS+2:0] mem_rdata,
    output logic                   renderAnt,
    output logic                   renderSugar,
    output logic                   renderNest,
    output logic                   render_viewLoc,
    output logic                   render_writeLoc,
    output logic [SIGNAL_BITS-1:0] renderSignal,
    output logic                   out_valid
);

    import render_fetch_pkg::*;

    localparam int CW = 10 - CELL_SHIFT;

    logic [CW-1:0]     unused_col;
    logic [CW-1:0]     unused_row;
    logic              in_grid;
    logic              interior;
    logic [ADDR_W-1:0] cell_addr;
    logic              view_hit;
    logic              write_hit;

    logic a_valid, a_in_grid, a_interior, a_view, a_write;
    logic b_valid, b_in_grid, b_interior, b_view, b_write;

    cell_word_t word;

    pixel_to_cell #(
        .CELL_SHIFT (CELL_SHIFT),
        .GRID_W     (GRID_W),
        .GRID_H     (GRID_H),
        .ADDR_W     (ADDR_W),
        .COORD_W    (10)
    ) u_p2c (
        .x        (DrawX),
        .y        (DrawY),
        .valid    (pix_valid),
        .col      (unused_col),
        .row      (unused_row),
        .in_grid  (in_grid),
        .interior (interior),
        .addr     (cell_addr)
    );

    assign view_hit  = in_grid && (cell_addr == view_loc);
    assign write_hit = in_grid && (cell_addr == write_loc);
    assign word      = mem_rdata;

    // Stage A: address is held off-grid so the RAM port stays quiet
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_addr   <= '0;
            a_valid    <= 1'b0;
            a_in_grid  <= 1'b0;
            a_interior <= 1'b0;
            a_view     <= 1'b0;
            a_write    <= 1'b0;
        end else begin
            if (in_grid)
                mem_addr <= cell_addr;
            a_valid    <= pix_valid;
            a_in_grid  <= in_grid;
            a_interior <= interior;
            a_view     <= view_hit;
            a_write    <= write_hit;
        end
    end

    // Stage B: sideband rides alongside the RAM's own read register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            b_valid    <= 1'b0;
            b_in_grid  <= 1'b0;
            b_interior <= 1'b0;
            b_view     <= 1'b0;
            b_write    <= 1'b0;
        end else begin
            b_valid    <= a_valid;
            b_in_grid  <= a_in_grid;
            b_interior <= a_interior;
            b_view     <= a_view;
            b_write    <= a_write;
        end
    end

    // Stage C: off-grid pixels present an empty cell
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            renderAnt       <= 1'b0;
            renderSugar     <= 1'b0;
            renderNest      <= 1'b0;
            render_viewLoc  <= 1'b0;
            render_writeLoc <= 1'b0;
            renderSignal    <= '0;
            out_valid       <= 1'b0;
        end else begin
            out_valid       <= b_valid;
            render_viewLoc  <= b_view;
            render_writeLoc <= b_write;
            if (b_in_grid) begin
                renderAnt    <= word.ant & b_interior;
                renderSugar  <= word.sugar;
                renderNest   <= word.nest;
                renderSignal <= word.signal;
            end else begin
                renderAnt    <= 1'b0;
                renderSugar  <= 1'b0;
                renderNest   <= 1'b0;
                renderSignal <= '0;
            end
        end
    end

endmodule

// File: tb/tb_render_fetch.sv
// Directed bench for render_fetch with a behavioural sync-read RAM.
module tb_render_fetch;

    logic        Clk;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pix_valid;
    logic [12:0] view_loc;
    logic [12:0] write_loc;
    logic [12:0] mem_addr;
    logic [11:0] mem_rdata;
    logic        renderAnt;
    logic        renderSugar;
    logic        renderNest;
    logic        render_viewLoc;
    logic        render_writeLoc;
    logic [8:0]  renderSignal;
    logic        out_valid;

    int vectors;
    int miscompares;

    logic [11:0] ram [0:8191];

    render_fetch dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .pix_valid       (pix_valid),
        .view_loc        (view_loc),
        .write_loc       (write_loc),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .renderAnt       (renderAnt),
        .renderSugar     (renderSugar),
        .renderNest      (renderNest),
        .render_viewLoc  (render_viewLoc),
        .render_writeLoc (render_writeLoc),
        .renderSignal    (renderSignal),
        .out_valid       (out_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_ff @(posedge Clk)
        mem_rdata <= ram[mem_addr];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(2);
        vectors++;
        if (mem_addr !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_addr: got %0d want 0", mem_addr);
        end
        vectors++;
        if ({out_valid, renderAnt, renderSugar, renderNest,
             render_viewLoc, render_writeLoc, renderSignal} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outs: got ov=%b sig=%0d want all 0",
                     out_valid, renderSignal);
        end
        Reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        DrawX = 10'd17; DrawY = 10'd9; pix_valid = 1'b1;
        tick(1);
        pix_valid = 1'b0;
        vectors++;
        if (mem_addr !== 13'd82) begin
            miscompares++;
            $display("FAIL basic_addr: got %0d want 82", mem_addr);
        end
        tick(2);
        vectors++;
        if ({out_valid, renderAnt, renderSugar, renderNest} !== 4'b1100) begin
            miscompares++;
            $display("FAIL basic_flags: got ov,ant,sug,nest=%b want 1100",
                     {out_valid, renderAnt, renderSugar, renderNest});
        end
        vectors++;
        if (renderSignal !== 9'd100) begin
            miscompares++;
            $display("FAIL basic_signal: got %0d want 100", renderSignal);
        end
    endtask

    task automatic test_border();
        DrawX = 10'd16; DrawY = 10'd9; pix_valid = 1'b1;
        tick(1);
        pix_valid = 1'b0;
        tick(2);
        vectors++;
        if ({out_valid, renderAnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL border_ant: got ov,ant=%b want 10",
                     {out_valid, renderAnt});
        end
        vectors++;
        if (renderSignal !== 9'd100) begin
            miscompares++;
            $display("FAIL border_signal: got %0d want 100", renderSignal);
        end
    endtask

    task automatic test_off_grid();
        DrawX = 10'd640; DrawY = 10'd100; pix_valid = 1'b1;
        tick(1);
        pix_valid = 1'b0;
        vectors++;
        if (mem_addr !== 13'd82) begin
            miscompares++;
            $display("FAIL offgrid_addr_hold: got %0d want 82", mem_addr);
        end
        tick(2);
        vectors++;
        if ({out_valid, renderAnt, renderSugar, renderNest,
             render_viewLoc, render_writeLoc, renderSignal}
            !== {1'b1, 14'd0}) begin
            miscompares++;
            $display("FAIL offgrid_outs: got ov=%b sig=%0d want ov=1 sig=0",
                     out_valid, renderSignal);
        end
    endtask

    task automatic test_view_write();
        view_loc = 13'd4799; write_loc = 13'd4799;
        DrawX = 10'd636; DrawY = 10'd476; pix_valid = 1'b1;
        tick(1);
        DrawX = 10'd628;
        tick(1);
        pix_valid = 1'b0;
        vectors++;
        if (mem_addr !== 13'd4798) begin
            miscompares++;
            $display("FAIL vw_addr: got %0d want 4798", mem_addr);
        end
        tick(1);
        vectors++;
        if ({render_viewLoc, render_writeLoc} !== 2'b11) begin
            miscompares++;
            $display("FAIL vw_hit: got %b want 11",
                     {render_viewLoc, render_writeLoc});
        end
        vectors++;
        if ({renderSugar, renderNest, renderSignal} !== {2'b11, 9'd7}) begin
            miscompares++;
            $display("FAIL vw_word: got sug=%b nest=%b sig=%0d want 1 1 7",
                     renderSugar, renderNest, renderSignal);
        end
        tick(1);
        vectors++;
        if ({out_valid, render_viewLoc, render_writeLoc} !== 3'b100) begin
            miscompares++;
            $display("FAIL vw_adjacent: got ov,v,w=%b want 100",
                     {out_valid, render_viewLoc, render_writeLoc});
        end
        view_loc = 13'h1fff; write_loc = 13'h1fff;
    endtask

    task automatic test_back_to_back();
        logic       pvh [0:639];
        logic       exp_ant;
        logic [8:0] exp_sig;
        int         j;
        DrawY = 10'd9;
        for (int i = 0; i < 642; i++) begin
            if (i < 640) begin
                DrawX     = 10'(i);
                pix_valid = (i % 5 != 2) && (i % 7 != 0);
                pvh[i]    = pix_valid;
            end else begin
                pix_valid = 1'b0;
            end
            tick(1);
            if (i >= 2) begin
                j       = i - 2;
                exp_sig = pvh[j] ? 9'((j >> 3) + 1) : 9'd0;
                exp_ant = pvh[j] && (j % 8 >= 1) && (j % 8 <= 6);
                vectors++;
                if ({out_valid, renderAnt, renderSignal}
                    !== {pvh[j], exp_ant, exp_sig}) begin
                    miscompares++;
                    $display("FAIL stream_px%0d: got ov=%b ant=%b sig=%0d want ov=%b ant=%b sig=%0d",
                             j, out_valid, renderAnt, renderSignal,
                             pvh[j], exp_ant, exp_sig);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        DrawY = 10'd9; pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DrawX = 10'(100 + i);
            tick(1);
        end
        Reset = 1'b1;
        #1;
        vectors++;
        if ({out_valid, renderAnt, renderSignal, mem_addr} !== 24'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got ov=%b sig=%0d addr=%0d want 0",
                     out_valid, renderSignal, mem_addr);
        end
        tick(2);
        Reset = 1'b0;
        pix_valid = 1'b0;
        tick(1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_flush: got ov=%b want 0", out_valid);
        end
        DrawX = 10'd200; pix_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            vectors++;
            if (out_valid !== (k == 3)) begin
                miscompares++;
                $display("FAIL midreset_resume_t%0d: got ov=%b want %b",
                         k, out_valid, (k == 3));
            end
        end
        vectors++;
        if (renderSignal !== 9'd26) begin
            miscompares++;
            $display("FAIL midreset_signal: got %0d want 26", renderSignal);
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        DrawX       = '0;
        DrawY       = '0;
        pix_valid   = 1'b0;
        view_loc    = 13'h1fff;
        write_loc   = 13'h1fff;
        for (int i = 0; i < 8192; i++)
            ram[i] = 12'h000;
        ram[82]   = {1'b1, 1'b0, 1'b0, 9'd100};
        ram[4799] = {1'b0, 1'b1, 1'b1, 9'd7};
        ram[4798] = {1'b1, 1'b0, 1'b0, 9'd3};

        test_reset();
        test_basic();
        test_border();
        test_off_grid();
        test_view_write();

        for (int c = 0; c < 80; c++)
            ram[80 + c] = {1'b1, 1'b0, 1'b0, 9'(c + 1)};
        test_back_to_back();
        test_mid_reset();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
